brammat_fill: RTL and testbench
===============================

Name: brammat_fill

Overview:
- Upstream feeder for the BRAM matrix stage.
- Drains 16 memory-controller FIFOs, each delivering one 64-bit word per entry, with first-word-fall-through.
- Presents the drained words as registered per-lane write requests plus a 1024-bit data bus.
- Sequences one complete fill of one BRAM bank half (left or right), including the pointer-clear pulse to the matrix before filling starts.

Parameters:
- LANES, 16, number of FIFO lanes; fixed by the matrix lane mapping.
- WORD, 64, bits per lane word (two 32-bit BRAM entries).
- DEPTH, 64, addresses per bank half of each BRAM.
- ROUNDS_A, 14, BRAM pairs served by lanes 0 and 1.
- ROUNDS_B, 13, BRAM pairs served by lanes 2..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a fill
- bank_sel  in  1  target bank half for this fill (0 = left, 1 = right)
- abort  in  1  cancel the fill in progress
- mcfifo_empty  in  16  per-lane FIFO empty flags
- mcfifo_data  in  1024  per-lane FWFT head data; lane i occupies [i*64 +: 64]
- mcfifo_pop  out  16  per-lane pop, combinational
- bram_reset  out  1  pointer clear to the matrix, registered
- fifo_write_req  out  16  per-lane write strobe, registered
- fifo_datain  out  1024  write data, registered, same lane packing as mcfifo_data
- lorrselect  out  1  bank half being written, registered
- busy  out  1  high in CLEAR and FILL
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all registered outputs 0; state IDLE; lane counters 0.
- Quota per lane: lanes 0,1 = DEPTH*ROUNDS_A = 896 words; lanes 2..15 = DEPTH*ROUNDS_B = 832 words. Lane counters are 10 bits wide.
- IDLE:
  - start=1 -> go to CLEAR, latch bank_sel into lorrselect.
- CLEAR (exactly one cycle):
  - bram_reset=1 and all lane counters cleared.
  - Then go to FILL.
  - bram_reset is 0 in every other state.
- FILL:
  - mcfifo_pop[i] = !mcfifo_empty[i] && cnt[i] < quota[i] && !abort. Lanes are independent.
  - Next edge: fifo_write_req[i] <= mcfifo_pop[i]. If popped, fifo_datain lane i <= mcfifo_data lane i; otherwise the lane data holds.
  - cnt[i] increments on each pop and saturates at quota; no pop is issued once a lane reaches quota.
  - Latency from pop to fifo_write_req is 1 cycle.
  - When every cnt equals its quota, go to DONE on the next edge. The final write_req is visible during that last FILL cycle.
- DONE (one cycle):
  - done=1, fifo_write_req=0, busy=0.
  - Then go to IDLE.
- lorrselect holds from CLEAR until the next start.
- abort in CLEAR or FILL:
  - Pops are suppressed the same cycle.
  - Next edge: state -> IDLE and fifo_write_req <= 0. No done pulse. Counters keep their values until the next CLEAR.
- start while not in IDLE is ignored. start and abort together in IDLE: abort wins and state stays IDLE.
- Empty FIFOs during FILL stall only that lane; other lanes continue.
- Asynchronous reset mid-fill returns everything to reset values immediately, with no done pulse.
- Total writes per completed fill: 2*896 + 14*832 = 13440, equal to 210 BRAM pairs * 64.

Optional Feature:
- Macro BRAMMAT_FILL_STALL_CNT_EN.
- When defined:
  - Adds output stall_count (out, 16 bits), cleared in CLEAR.
  - Increments in every FILL cycle where at least one lane has cnt < quota and is empty; saturates at 16'hFFFF.
  - Holds its value after DONE or abort.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with bank_sel=1 and all FIFOs non-empty -> bram_reset high for exactly 1 cycle; lorrselect=1; fifo_write_req=16'hFFFF starting 2 cycles after start; lanes 2..15 drop after 832 writes, lanes 0,1 after 896; done pulses once, on the cycle after the last write_req.
- Lane 5 FIFO loaded with an incrementing pattern 0..831 -> fifo_datain[383:320] matches the pattern in order, one word per fifo_write_req[5]; the 833rd entry is never popped.
- Lane 0 empty for 100 cycles mid-fill, all other lanes full -> only mcfifo_pop[0] is 0 during the gap; the fill still completes with exactly 896 lane-0 writes. With the macro defined, stall_count = 100 over the gap (plus any empty-lane cycles after other lanes finish, computed by the bench).
- abort asserted 50 cycles into FILL -> mcfifo_pop=0 that same cycle; fifo_write_req=0 and busy=0 the next cycle; no done pulse; a subsequent start performs a full fill with correct counts.
- start pulsed again during FILL, and start+abort together in IDLE -> no state change and no bram_reset pulse in either case.
- Asynchronous reset asserted between clock edges mid-fill -> all outputs 0 before the next edge; the next start performs a clean fill.

Source files
------------

// File: rtl/brammat_fill.sv
// Fill sequencer for the BRAM matrix: drains 16 FWFT memory-controller FIFOs into one bank half.
// Optional stall counter output enabled by defining BRAMMAT_FILL_STALL_CNT_EN.

module brammat_fill_lane #(
  parameter int WORD  = 64,
  parameter int QUOTA = 832,
  parameter int CW    = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            fill_en,
  input  logic            empty,
  input  logic [WORD-1:0] din,
  output logic            pop,
  output logic            wr,
  output logic [WORD-1:0] dout,
  output logic            at_quota
);
  localparam logic [CW-1:0] QUOTA_C = CW'(QUOTA);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [WORD-1:0] dat_q, dat_d;

  // Counter stops exactly at quota because pop is blocked there.
  always_comb begin
    at_quota = (cnt_q == QUOTA_C);
    pop      = fill_en && !empty && !at_quota;
    wr_d     = pop;
    dat_d    = pop ? din : dat_q;
    cnt_d    = cnt_q;
    if (clear)    cnt_d = '0;
    else if (pop) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      dat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      dat_q <= dat_d;
    end
  end

  assign wr   = wr_q;
  assign dout = dat_q;
endmodule

module brammat_fill #(
  parameter int LANES    = 16,
  parameter int WORD     = 64,
  parameter int DEPTH    = 64,
  parameter int ROUNDS_A = 14,
  parameter int ROUNDS_B = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bank_sel,
  input  logic                  abort,
  input  logic [LANES-1:0]      mcfifo_empty,
  input  logic [LANES*WORD-1:0] mcfifo_data,
  output logic [LANES-1:0]      mcfifo_pop,
  output logic                  bram_reset,
  output logic [LANES-1:0]      fifo_write_req,
  output logic [LANES*WORD-1:0] fifo_datain,
  output logic                  lorrselect,
  output logic                  busy,
`ifdef BRAMMAT_FILL_STALL_CNT_EN
  output logic                  done,
  output logic [15:0]           stall_count
`else
  output logic                  done
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FILL, S_DONE} state_t;

  state_t state_q, state_d;
  logic   lorr_q, lorr_d;
  logic   bram_reset_q, bram_reset_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [LANES-1:0]           at_quota;
  logic [LANES-1:0][WORD-1:0] lane_dat;
  logic                       fill_en, clear;

  assign fill_en = (state_q == S_FILL) && !abort;
  assign clear   = (state_q == S_CLEAR);

  // Lanes 0 and 1 serve one more BRAM pair each than the rest.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    brammat_fill_lane #(
      .WORD (WORD),
      .QUOTA(i < 2 ? DEPTH*ROUNDS_A : DEPTH*ROUNDS_B)
    ) u_lane (
      .clk     (clk),
      .rst     (reset),
      .clear   (clear),
      .fill_en (fill_en),
      .empty   (mcfifo_empty[i]),
      .din     (mcfifo_data[i*WORD +: WORD]),
      .pop     (mcfifo_pop[i]),
      .wr      (fifo_write_req[i]),
      .dout    (lane_dat[i]),
      .at_quota(at_quota[i])
    );
  end

  assign fifo_datain = lane_dat;

  always_comb begin
    state_d = state_q;
    lorr_d  = lorr_q;
    case (state_q)
      S_IDLE:  if (start && !abort) begin
                 state_d = S_CLEAR;
                 lorr_d  = bank_sel;
               end
      S_CLEAR: state_d = abort ? S_IDLE : S_FILL;
      S_FILL:  if (abort)          state_d = S_IDLE;
               else if (&at_quota) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    bram_reset_d = (state_d == S_CLEAR);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_FILL);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lorr_q       <= 1'b0;
      bram_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lorr_q       <= lorr_d;
      bram_reset_q <= bram_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lorrselect = lorr_q;
  assign bram_reset = bram_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef BRAMMAT_FILL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        starving;

  // A cycle counts as stalled when any unfinished lane has nothing to give.
  always_comb begin
    starving = |(mcfifo_empty & ~at_quota);
    stall_d  = stall_q;
    if (state_q == S_CLEAR)
      stall_d = '0;
    else if (state_q == S_FILL && starving && stall_q != 16'hFFFF)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_brammat_fill.sv
// Directed bench for brammat_fill: table of fill scenarios plus reset/abort/restart corner sequences.
module tb_brammat_fill;
  logic          clk = 1'b0;
  logic          reset, start, bank_sel, abort;
  logic [15:0]   mcfifo_empty, mcfifo_pop, fifo_write_req;
  logic [1023:0] mcfifo_data, fifo_datain;
  logic          bram_reset, lorrselect, busy, done;
`ifdef BRAMMAT_FILL_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  always #5 clk = ~clk;

  brammat_fill dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bank_sel      (bank_sel),
    .abort         (abort),
    .mcfifo_empty  (mcfifo_empty),
    .mcfifo_data   (mcfifo_data),
    .mcfifo_pop    (mcfifo_pop),
    .bram_reset    (bram_reset),
    .fifo_write_req(fifo_write_req),
    .fifo_datain   (fifo_datain),
    .lorrselect    (lorrselect),
    .busy          (busy),
`ifdef BRAMMAT_FILL_STALL_CNT_EN
    .done          (done),
    .stall_count   (stall_count)
`else
    .done          (done)
`endif
  );

  int n_cmp = 0, n_err = 0;
  int head[16]  = '{default: 0};   // words popped from each FIFO so far
  int wcnt[16]  = '{default: 0};   // words seen on the write side so far
  int fillw[16] = '{default: 0};   // writes seen in the current fill
  int donecnt   = 0;

  function automatic int quota(input int i);
    return (i < 2) ? 896 : 832;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // FWFT FIFO model: head word of lane i is {lane, A5A5, sequence number}.
  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (mcfifo_pop[i]) head[i] <= head[i] + 1;

  always_comb
    for (int i = 0; i < 16; i++)
      mcfifo_data[i*64 +: 64] = {16'(i), 16'hA5A5, 32'(head[i])};

  // Write-side scoreboard: every write must carry the next word of its lane, in order.
  always @(negedge clk) begin
    for (int i = 0; i < 16; i++)
      if (fifo_write_req[i] === 1'b1) begin
        chk("datain_order", fifo_datain[i*64 +: 64], {16'(i), 16'hA5A5, 32'(wcnt[i])});
        wcnt[i]++;
        fillw[i]++;
      end
    if (done === 1'b1) donecnt++;
  end

  typedef struct {
    bit bank;
    int gap_lane;
    int gap_start;
    int gap_len;
    int abort_at;
    int restart_at;
  } vec_t;

  task automatic run_fill(input vec_t v);
    int  c, exp_end, e, dc0;
    bit  got_done;
    for (int i = 0; i < 16; i++) fillw[i] = 0;
    dc0 = donecnt;
    exp_end = 0;
    for (int i = 0; i < 16; i++) begin
      e = quota(i) + ((v.gap_len > 0 && i == v.gap_lane) ? v.gap_len : 0);
      if (e > exp_end) exp_end = e;
    end
    exp_end = exp_end + 1;
    start = 1'b1; bank_sel = v.bank;
    @(negedge clk); start = 1'b0; #1;
    chk("clear_bram_reset", bram_reset, 1);
    chk("clear_lorr", lorrselect, v.bank);
    chk("clear_busy", busy, 1);
    @(negedge clk);
    c = 0; got_done = 0;
    while (c < 3000 && !got_done) begin
      if (v.gap_len > 0 && c == v.gap_start) mcfifo_empty[v.gap_lane] = 1'b1;
      if (v.gap_len > 0 && c == v.gap_start + v.gap_len) mcfifo_empty[v.gap_lane] = 1'b0;
      start = (c == v.restart_at); bank_sel = ~v.bank;
      abort = (c == v.abort_at);
      #1;
      if (c == 0) begin
        chk("fill0_bram_reset", bram_reset, 0);
        chk("fill0_write_req", fifo_write_req, 0);
        chk("fill0_pop", mcfifo_pop, 16'hFFFF);
      end
      if (c == 1 && v.abort_at != 0) chk("fill1_write_req", fifo_write_req, 16'hFFFF);
      if (v.gap_len > 0 && c == v.gap_start + 1)
        chk("gap_pop", mcfifo_pop, 16'hFFFF & ~(16'd1 << v.gap_lane));
      if (c == 850 && v.gap_len == 0 && v.abort_at < 0) chk("tail_pop", mcfifo_pop, 16'h0003);
      if (v.restart_at >= 0 && c == v.restart_at + 1) begin
        chk("restart_bram_reset", bram_reset, 0);
        chk("restart_busy", busy, 1);
      end
      if (c == v.abort_at) begin
        chk("abort_pop", mcfifo_pop, 0);
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_write_req", fifo_write_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", donecnt - dc0, 0);
        chk("abort_writes_l0", fillw[0], v.abort_at);
        chk("abort_writes_l2", fillw[2], v.abort_at);
`ifdef BRAMMAT_FILL_STALL_CNT_EN
        chk("abort_stall", stall_count, 0);
`endif
        return;
      end
      if (done === 1'b1) begin
        got_done = 1;
        chk("done_cycle", c, exp_end);
        chk("done_write_req", fifo_write_req, 0);
        chk("done_busy", busy, 0);
      end else begin
        @(negedge clk); c++;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      n_cmp++; n_err++;
      $display("FAIL fill_timeout: got no done in %0d cycles want done at %0d", c, exp_end);
    end
    for (int i = 0; i < 16; i++) chk("lane_writes", fillw[i], quota(i));
    chk("fill_lorr", lorrselect, v.bank);
`ifdef BRAMMAT_FILL_STALL_CNT_EN
    chk("stall_count", stall_count, v.gap_len);
`endif
    @(negedge clk); #1;
    chk("done_one_pulse", done, 0);
    chk("done_count", donecnt - dc0, 1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 0, 0,   0,   -1, -1};  // plain fill, right half
    vecs[1] = '{1'b0, 0, 200, 100, -1, -1};  // lane 0 starved 100 cycles
    vecs[2] = '{1'b1, 0, 0,   0,   50, -1};  // abort 50 cycles in
    vecs[3] = '{1'b0, 0, 0,   0,   -1, -1};  // full fill after abort
    vecs[4] = '{1'b1, 0, 0,   0,   -1, 100}; // start re-pulsed during FILL
    vecs[5] = '{1'b0, 9, 400, 500, -1, -1};  // short lane stalled past long lanes' end

    reset = 1'b1; start = 1'b0; bank_sel = 1'b0; abort = 1'b0; mcfifo_empty = '0;
    #1;
    chk("rst_write_req", fifo_write_req, 0);
    chk("rst_datain", fifo_datain[63:0], 0);
    chk("rst_bram_reset", bram_reset, 0);
    chk("rst_lorr", lorrselect, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop", mcfifo_pop, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_fill(vecs[k]);
      if (k == 0) begin
        repeat (3) @(negedge clk);
        chk("lane5_popped", head[5], 832);
        chk("lane0_popped", head[0], 896);
      end
      @(negedge clk);
    end

    // start together with abort in IDLE must do nothing
    start = 1'b1; abort = 1'b1; bank_sel = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0; #1;
    chk("startabort_busy", busy, 0);
    chk("startabort_bram_reset", bram_reset, 0);
    chk("startabort_lorr", lorrselect, 0);
    @(negedge clk); #1;
    chk("startabort_busy2", busy, 0);
    chk("startabort_pop", mcfifo_pop, 0);

    // asynchronous reset between edges, mid-fill
    begin
      int dc0;
      dc0 = donecnt;
      start = 1'b1; bank_sel = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (300) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_write_req", fifo_write_req, 0);
      chk("arst_datain_l0", fifo_datain[63:0], 0);
      chk("arst_datain_l15", fifo_datain[1023:960], 0);
      chk("arst_bram_reset", bram_reset, 0);
      chk("arst_lorr", lorrselect, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_pop", mcfifo_pop, 0);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 16; i++) wcnt[i] = head[i];
      repeat (3) @(negedge clk);
      chk("arst_no_done", donecnt - dc0, 0);
    end
    run_fill(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
